// File: rtl/ysyx_24090010_pkg.sv
// Shared types and constants for the ysyx_24090010 core.
// Holds the IFU state encoding, AXI response codes and the boot PC.
package ysyx_24090010_pkg;

  typedef enum logic [2:0] {
    IFU_BOOT = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    IFU_OUT  = 3'd3,
    IFU_EXEC = 3'd4
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24090010_ifu_if.sv
// Fetch-unit bus: AXI4-Lite read channel (AR/R), decode handshake, commit PC.
// master = IFU side, slave = memory/decode/commit side.
interface ysyx_24090010_ifu_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_fault;
  logic        npc_valid;
  logic [31:0] npc;

  modport master (
    output araddr, arvalid, rready, inst_valid, pc, inst, inst_fault,
    input  arready, rdata, rresp, rvalid, inst_ready, npc_valid, npc
  );

  modport slave (
    input  araddr, arvalid, rready, inst_valid, pc, inst, inst_fault,
    output arready, rdata, rresp, rvalid, inst_ready, npc_valid, npc
  );

endinterface

// File: rtl/ysyx_24090010_ifu.sv
// Multi-cycle instruction fetch: one AR/R read per round, present {pc, inst} to decode,
// then wait for the committed next PC. Outputs come from registers/state only.
module ysyx_24090010_ifu
  import ysyx_24090010_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_24090010_ifu_if.master        bus,
  output logic [31:0]                fetch_cnt
);

  localparam logic [2:0] S_BOOT = IFU_BOOT;
  localparam logic [2:0] S_REQ  = IFU_REQ;
  localparam logic [2:0] S_WAIT = IFU_WAIT;
  localparam logic [2:0] S_OUT  = IFU_OUT;
  localparam logic [2:0] S_EXEC = IFU_EXEC;

  logic [2:0]  state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        fault_q;
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      fault_q     <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      case (state_q)
        S_BOOT: state_q <= S_REQ;
        S_REQ: begin
          if (bus.arready) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.rvalid) begin
            inst_q      <= bus.rdata;
            // A faulting fetch still flows to decode; the trap logic owns it.
            fault_q     <= (bus.rresp != RESP_OKAY);
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.inst_ready) state_q <= S_EXEC;
        end
        S_EXEC: begin
          // npc is taken as-is; alignment is checked downstream.
          if (bus.npc_valid) begin
            pc_q    <= bus.npc;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign bus.arvalid    = (state_q == S_REQ);
  assign bus.araddr     = pc_q;
  assign bus.rready     = (state_q == S_WAIT);
  assign bus.inst_valid = (state_q == S_OUT);
  assign bus.pc         = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_fault = fault_q;
  assign fetch_cnt      = fetch_cnt_q;

endmodule

// File: doc/ysyx_24090010_ifu.md
# ysyx_24090010_ifu

Instruction fetch unit of the multi-cycle RV32 core, sitting directly upstream of the decode stage. It holds the architectural PC and fetches one 32-bit instruction per round over an AXI4-Lite-style read channel (AR/R only). It presents `{pc, inst}` to decode with a valid/ready handshake, then waits for the committed next PC before fetching again. One outstanding transaction, no prefetch.

## Interface

Parameters:
- `RESET_PC`, default 32'h8000_0000: PC value loaded on reset.

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset rst, synchronous, active-high.
- `araddr` out 32: fetch address, equals `pc` while `arvalid`.
- `arvalid` out 1: read-address valid.
- `arready` in 1: read-address ready from memory.
- `rdata` in 32: returned instruction word.
- `rresp` in 2: response code; 2'b00 OKAY, anything else is an access fault.
- `rvalid` in 1: read-data valid.
- `rready` out 1: read-data ready.
- `inst_valid` out 1: `{pc, inst, inst_fault}` valid to decode.
- `inst_ready` in 1: decode accepts.
- `pc` out 32: PC of the instruction being fetched or presented.
- `inst` out 32: latched instruction word.
- `inst_fault` out 1: latched `rresp != 0` for this fetch.
- `npc_valid` in 1: next PC from writeback/commit is valid.
- `npc` in 32: next PC.
- `fetch_cnt` out 32: completed fetches (R handshakes), wraps at 2^32.

## Operation

- FSM states: BOOT, REQ, WAIT, OUT, EXEC.
- BOOT → REQ unconditionally; holds only the cycle after reset.
- REQ: `arvalid`=1, `araddr`=`pc`. On `arvalid && arready` → WAIT.
- WAIT: `rready`=1. On `rvalid`, latch `inst`<=`rdata`, `inst_fault`<=(`rresp`!=0), increment `fetch_cnt`, → OUT.
- OUT: `inst_valid`=1; `pc`, `inst` and `inst_fault` are held stable. On `inst_ready` → EXEC.
- EXEC: wait. On `npc_valid`, `pc`<=`npc`, → REQ.
- `npc_valid` is ignored in every state except EXEC.
- `rvalid` is ignored outside WAIT. `arready` is ignored outside REQ.
- `npc[1:0]` != 0 is passed through unmodified. Misalignment is detected downstream, not here.
- A faulting fetch still goes through OUT/EXEC normally. Decode/trap logic owns the response.
- Outputs are decoded from state and registers only; no combinational path from inputs to outputs.

## Timing

- Reset values:
  - state=BOOT, `pc`=RESET_PC, `inst`=0, `inst_fault`=0, `fetch_cnt`=0.
  - `arvalid`=`rready`=`inst_valid`=0.
- `rst` mid-transaction drops the transaction on the next edge. The memory-side consequences are the interconnect's concern.
- First `arvalid` appears 2 cycles after the first edge with `rst` low (BOOT, then REQ).
- Minimum round, zero-wait memory with ready inputs high: REQ 1, WAIT 1, OUT 1, EXEC 1 = 4 cycles per instruction.
- `arvalid` stays high until handshake (AXI rule). `inst_valid` stays high until `inst_ready`.
- `fetch_cnt` increments exactly on WAIT && `rvalid`. 32'hFFFF_FFFF + 1 wraps to 0.

## Structure

- Shared package `ysyx_24090010_pkg`:
  - IFU state enum (3-bit).
  - `RESP_OKAY` = 2'b00.
  - Default reset PC constant `RESET_PC_DEFAULT`.
- Single module, no sub-module. The counter and the FSM are both trivial.

## Test plan

- Reset, then `arready`=`rvalid`=`inst_ready`=1, `rdata`=32'h00100073, `npc_valid` on EXEC with `npc`=0x80000004:
  - `araddr`=0x80000000 at cycle 2 after reset release.
  - `inst_valid` with `inst`=32'h00100073 at cycle 4.
  - Next `araddr`=0x80000004.
  - `fetch_cnt`=1.
- `arready` low 3 cycles in REQ:
  - `arvalid` and `araddr` held stable all 3 cycles.
  - Exactly one AR handshake.
- `rresp`=2'b10, `rdata`=32'hDEADBEEF:
  - `inst_valid` with `inst_fault`=1 and `inst`=32'hDEADBEEF.
  - FSM proceeds to EXEC normally.
- `inst_ready` low 5 cycles in OUT, `npc_valid` pulsed during OUT:
  - Outputs held stable.
  - The pulse is ignored and `pc` is unchanged.
  - After `inst_ready`, the FSM waits in EXEC for a new `npc_valid`.
- `rst` asserted during WAIT:
  - Next cycle: state=BOOT, `pc`=RESET_PC, `rready`=0, `fetch_cnt`=0.
  - A late `rvalid` in BOOT is ignored.
- Force `fetch_cnt`=32'hFFFF_FFFF, complete one fetch:
  - `fetch_cnt`=0.
